// File: rtl/truth_table_sequencer.sv
// Sweeps an N_IN-input combinational FUT through every input vector and records
// its output per vector in a truth table. Define TRUTH_EXPECT_CHECK_EN to add an expected-table compare.
module truth_table_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      fut_in,
  input  logic                 fut_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   truth
`ifdef TRUTH_EXPECT_CHECK_EN
  ,
  input  logic [2**N_IN-1:0]   expected,
  output logic                 pass,
  output logic [2**N_IN-1:0]   mismatch
`endif
);

  localparam int TW = 2 ** N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   RELOAD   = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state_r,  state_nxt_s;
  logic [CW-1:0]   cnt_r,    cnt_nxt_s;
  logic [N_IN-1:0] fut_in_r, fut_in_nxt_s;
  logic            busy_r,   busy_nxt_s;
  logic            done_r,   done_nxt_s;
  logic [TW-1:0]   truth_r,  truth_nxt_s;
`ifdef TRUTH_EXPECT_CHECK_EN
  logic [TW-1:0]   exp_r,      exp_nxt_s;
  logic            pass_r,     pass_nxt_s;
  logic [TW-1:0]   mismatch_r, mismatch_nxt_s;
`endif

  // Next-state and next-output logic for the sweep controller.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    fut_in_nxt_s = fut_in_r;
    busy_nxt_s   = busy_r;
    done_nxt_s   = 1'b0;
    truth_nxt_s  = truth_r;
`ifdef TRUTH_EXPECT_CHECK_EN
    exp_nxt_s      = exp_r;
    pass_nxt_s     = pass_r;
    mismatch_nxt_s = mismatch_r;
`endif
    case (state_r)
      ST_IDLE: begin
        fut_in_nxt_s = '0;
        if (start) begin
          state_nxt_s = ST_SETTLE;
          truth_nxt_s = '0;
          busy_nxt_s  = 1'b1;
          cnt_nxt_s   = RELOAD;
`ifdef TRUTH_EXPECT_CHECK_EN
          exp_nxt_s      = expected;
          pass_nxt_s     = 1'b0;
          mismatch_nxt_s = '0;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == '0) begin
          state_nxt_s = ST_SAMPLE;
        end else begin
          cnt_nxt_s = cnt_r - CW'(1);
        end
      end
      ST_SAMPLE: begin
        truth_nxt_s[fut_in_r] = fut_out;
        if (fut_in_r == LAST_VEC) begin
          state_nxt_s = ST_DONE;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
`ifdef TRUTH_EXPECT_CHECK_EN
          // Compare against the table including this final sample.
          mismatch_nxt_s = truth_nxt_s ^ exp_r;
          pass_nxt_s     = ((truth_nxt_s ^ exp_r) == {TW{1'b0}});
`endif
        end else begin
          state_nxt_s  = ST_SETTLE;
          fut_in_nxt_s = fut_in_r + N_IN'(1);
          cnt_nxt_s    = RELOAD;
        end
      end
      ST_DONE: begin
        state_nxt_s  = ST_IDLE;
        fut_in_nxt_s = '0;
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        fut_in_nxt_s = '0;
        busy_nxt_s   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      fut_in_r   <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      truth_r    <= '0;
`ifdef TRUTH_EXPECT_CHECK_EN
      exp_r      <= '0;
      pass_r     <= 1'b0;
      mismatch_r <= '0;
`endif
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      fut_in_r   <= fut_in_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      truth_r    <= truth_nxt_s;
`ifdef TRUTH_EXPECT_CHECK_EN
      exp_r      <= exp_nxt_s;
      pass_r     <= pass_nxt_s;
      mismatch_r <= mismatch_nxt_s;
`endif
    end
  end

  assign fut_in = fut_in_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign truth  = truth_r;
`ifdef TRUTH_EXPECT_CHECK_EN
  assign pass     = pass_r;
  assign mismatch = mismatch_r;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: one instance at SETTLE=20, one at SETTLE=1,
// each driving a behavioural two-input gate as FUT.
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [1:0] fut_in0, fut_in1;
  logic       fut_out0, fut_out1;
  logic       busy0, busy1, done0, done1;
  logic [3:0] truth0, truth1;
  logic       glitch0;
  int         sel0, sel1;
  int         checks, failures;
`ifdef TRUTH_EXPECT_CHECK_EN
  logic [3:0] expected0, expected1, mismatch0, mismatch1;
  logic       pass0, pass1;
`endif

  always #5 clk = ~clk;

  // sel: 0 AND, 1 OR, 2 XOR, 3 NAND
  function automatic logic fut_fn(int sel, logic [1:0] v);
    case (sel)
      0:       return v[1] & v[0];
      1:       return v[1] | v[0];
      2:       return v[1] ^ v[0];
      3:       return ~(v[1] & v[0]);
      default: return 1'b0;
    endcase
  endfunction

  assign fut_out0 = fut_fn(sel0, fut_in0) ^ glitch0;
  assign fut_out1 = fut_fn(sel1, fut_in1);

  truth_table_sequencer #(.N_IN(2), .SETTLE(20)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .fut_in(fut_in0), .fut_out(fut_out0),
    .busy(busy0), .done(done0), .truth(truth0)
`ifdef TRUTH_EXPECT_CHECK_EN
    , .expected(expected0), .pass(pass0), .mismatch(mismatch0)
`endif
  );

  truth_table_sequencer #(.N_IN(2), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .fut_in(fut_in1), .fut_out(fut_out1),
    .busy(busy1), .done(done1), .truth(truth1)
`ifdef TRUTH_EXPECT_CHECK_EN
    , .expected(expected1), .pass(pass1), .mismatch(mismatch1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; afterwards the bench sits in cycle 1 of the sweep.
  task automatic start_sweep0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (fut_in0 !== 2'b00) begin failures++; $display("FAIL reset_fut_in got=%b exp=00", fut_in0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done0); end
    checks++; if (truth0 !== 4'b0000) begin failures++; $display("FAIL reset_truth got=%b exp=0000", truth0); end
    checks++; if (truth1 !== 4'b0000 || busy1 !== 1'b0) begin failures++; $display("FAIL reset_dut1 got truth=%b busy=%b exp truth=0000 busy=0", truth1, busy1); end
  endtask

  task automatic test_and_sweep();
    int         n_done = 0;
    int         done_at = -1;
    logic       exp_busy;
    logic [1:0] exp_fi;
    sel0 = 0;
    start_sweep0();
    for (int c = 1; c <= 100; c++) begin
      exp_busy = (c <= 84);
      exp_fi   = (c <= 84) ? 2'((c - 1) / 21) : ((c == 85) ? 2'b11 : 2'b00);
      checks++; if (busy0 !== exp_busy) begin failures++; $display("FAIL and_busy cycle=%0d got=%b exp=%b", c, busy0, exp_busy); end
      checks++; if (fut_in0 !== exp_fi) begin failures++; $display("FAIL and_fut_in cycle=%0d got=%b exp=%b", c, fut_in0, exp_fi); end
      if (done0 === 1'b1) begin
        n_done++;
        done_at = c;
        checks++; if (truth0 !== 4'b1000) begin failures++; $display("FAIL and_truth_at_done got=%b exp=1000", truth0); end
      end
      tick();
    end
    checks++; if (n_done != 1) begin failures++; $display("FAIL and_done_count got=%0d exp=1", n_done); end
    checks++; if (done_at != 85) begin failures++; $display("FAIL and_done_cycle got=%0d exp=85", done_at); end
    checks++; if (truth0 !== 4'b1000) begin failures++; $display("FAIL and_truth_hold got=%b exp=1000", truth0); end
  endtask

  task automatic test_settle1_ignore_start();
    int         n_done = 0;
    int         done_at = -1;
    logic [1:0] exp_fi;
    sel1 = 2;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      start1 = (c == 3) || (c == 9);
      exp_fi = (c <= 8) ? 2'((c - 1) / 2) : ((c == 9) ? 2'b11 : 2'b00);
      checks++; if (fut_in1 !== exp_fi) begin failures++; $display("FAIL xor_fut_in cycle=%0d got=%b exp=%b", c, fut_in1, exp_fi); end
      checks++; if (busy1 !== (c <= 8)) begin failures++; $display("FAIL xor_busy cycle=%0d got=%b exp=%b", c, busy1, (c <= 8)); end
      if (done1 === 1'b1) begin
        n_done++;
        done_at = c;
      end
      tick();
    end
    start1 = 1'b0;
    checks++; if (n_done != 1) begin failures++; $display("FAIL xor_done_count got=%0d exp=1", n_done); end
    checks++; if (done_at != 9) begin failures++; $display("FAIL xor_done_cycle got=%0d exp=9", done_at); end
    checks++; if (truth1 !== 4'b0110) begin failures++; $display("FAIL xor_truth got=%b exp=0110", truth1); end
  endtask

  task automatic test_reset_mid_sweep();
    int n_done = 0;
    sel0 = 1;
    start_sweep0();
    for (int c = 1; c < 50; c++) tick();
    checks++; if (fut_in0 !== 2'b10) begin failures++; $display("FAIL mid_pre_fut_in got=%b exp=10", fut_in0); end
    checks++; if (truth0 !== 4'b0010) begin failures++; $display("FAIL mid_pre_truth got=%b exp=0010", truth0); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (fut_in0 !== 2'b00) begin failures++; $display("FAIL mid_fut_in got=%b exp=00", fut_in0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy0); end
    checks++; if (truth0 !== 4'b0000) begin failures++; $display("FAIL mid_truth got=%b exp=0000", truth0); end
    for (int c = 0; c < 100; c++) begin
      if (done0 === 1'b1 || busy0 === 1'b1) n_done++;
      tick();
    end
    checks++; if (n_done != 0) begin failures++; $display("FAIL mid_no_done got=%0d active cycles exp=0", n_done); end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int done_t[3];
    sel0 = 1;
    start0 = 1'b1;
    tick();
    for (int c = 1; c <= 270; c++) begin
      if (c >= 200) start0 = 1'b0;
      if (c == 87 || c == 173) begin
        checks++; if (truth0 !== 4'b0000 || busy0 !== 1'b1) begin failures++; $display("FAIL b2b_restart cycle=%0d got truth=%b busy=%b exp truth=0000 busy=1", c, truth0, busy0); end
      end
      if (done0 === 1'b1) begin
        if (n_done < 3) done_t[n_done] = c;
        n_done++;
        checks++; if (truth0 !== 4'b1110) begin failures++; $display("FAIL b2b_truth cycle=%0d got=%b exp=1110", c, truth0); end
      end
      tick();
    end
    start0 = 1'b0;
    checks++; if (n_done != 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", n_done); end
    if (n_done >= 3) begin
      checks++; if (done_t[0] != 85 || done_t[1] != 171 || done_t[2] != 257) begin failures++; $display("FAIL b2b_done_cycles got=%0d,%0d,%0d exp=85,171,257", done_t[0], done_t[1], done_t[2]); end
    end
  endtask

  task automatic test_glitch();
    int n_done = 0;
    sel0 = 3;
    start_sweep0();
    for (int c = 1; c <= 90; c++) begin
      glitch0 = (c <= 84 && (c % 21) != 0) ? 1'(c % 2) : 1'b0;
      if (done0 === 1'b1) n_done++;
      tick();
    end
    glitch0 = 1'b0;
    checks++; if (n_done != 1) begin failures++; $display("FAIL glitch_done_count got=%0d exp=1", n_done); end
    checks++; if (truth0 !== 4'b0111) begin failures++; $display("FAIL glitch_truth got=%b exp=0111", truth0); end
  endtask

`ifdef TRUTH_EXPECT_CHECK_EN
  task automatic test_expect_check();
    sel0 = 0;
    expected0 = 4'b1000;
    start_sweep0();
    expected0 = 4'b0000;
    for (int c = 1; c <= 90; c++) begin
      if (c == 85) begin
        checks++; if (pass0 !== 1'b1 || mismatch0 !== 4'b0000) begin failures++; $display("FAIL exp_match got pass=%b mismatch=%b exp pass=1 mismatch=0000", pass0, mismatch0); end
      end
      tick();
    end
    checks++; if (pass0 !== 1'b1) begin failures++; $display("FAIL exp_pass_hold got=%b exp=1", pass0); end
    expected0 = 4'b1001;
    start_sweep0();
    expected0 = 4'b1000;
    checks++; if (pass0 !== 1'b0 || mismatch0 !== 4'b0000) begin failures++; $display("FAIL exp_clear got pass=%b mismatch=%b exp pass=0 mismatch=0000", pass0, mismatch0); end
    for (int c = 1; c <= 90; c++) begin
      if (c == 85) begin
        checks++; if (pass0 !== 1'b0 || mismatch0 !== 4'b0001) begin failures++; $display("FAIL exp_mismatch got pass=%b mismatch=%b exp pass=0 mismatch=0001", pass0, mismatch0); end
      end
      tick();
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    glitch0 = 1'b0;
    sel0 = 0;
    sel1 = 0;
`ifdef TRUTH_EXPECT_CHECK_EN
    expected0 = 4'b0000;
    expected1 = 4'b0000;
`endif
    test_reset();
    test_and_sweep();
    test_settle1_ignore_start();
    test_reset_mid_sweep();
    test_back_to_back();
    test_glitch();
`ifdef TRUTH_EXPECT_CHECK_EN
    test_expect_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
